// File: rtl/relu_result_writeback.sv
// Captures per-unit ReLU results on done_in and drains them, lowest active unit
// first, into a wrapping output image buffer with a registered host read port.
module relu_result_writeback #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int NUM_UNITS    = 2,
  localparam int DEPTH       = IMAGE_WIDTH * IMAGE_HEIGHT,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic [AW-1:0]                        base_addr,
  input  logic                                 done_in,
  input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] relu_in,
  input  logic [NUM_UNITS-1:0]                 active_units,
  input  logic                                 rd_en,
  input  logic [AW-1:0]                        rd_addr,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 rd_valid,
  output logic [AW:0]                          result_count,
  output logic                                 busy,
  output logic                                 full,
  output logic                                 overflow
);

  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_e;

  state_e                              state_q, state_d;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] cap_q, cap_d;
  logic [NUM_UNITS-1:0]                mask_q, mask_d;
  logic [AW-1:0]                       base_q, base_d;
  logic [AW:0]                         count_q, count_d;
  logic                                ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]               rd_data_q;
  logic                                rd_valid_q;
  logic                                we_s;
  logic                                full_s;
  logic [UW-1:0]                       sel_s;
  logic [NUM_UNITS-1:0]                mask_rem_s;
  logic [AW:0]                         sum_s;
  logic [AW-1:0]                       waddr_s;
  logic [DATA_WIDTH-1:0]               mem [DEPTH];

  function automatic logic [UW-1:0] lowest_idx(input logic [NUM_UNITS-1:0] m);
    logic [UW-1:0] idx;
    idx = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = UW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Write address: base plus fill level, wrapped into the buffer.
  always_comb begin
    full_s = (count_q == (AW+1)'(DEPTH));
    sel_s  = lowest_idx(mask_q);
    sum_s  = (AW+1)'(base_q) + count_q;
    if (sum_s >= (AW+1)'(DEPTH)) begin
      waddr_s = AW'(sum_s - (AW+1)'(DEPTH));
    end else begin
      waddr_s = AW'(sum_s);
    end
    mask_rem_s        = mask_q;
    mask_rem_s[sel_s] = 1'b0;
  end

  // Capture/drain next-state logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    mask_d  = mask_q;
    base_d  = base_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    we_s    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      mask_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      base_d  = base_addr;
    end else begin
      case (state_q)
        IDLE: begin
          if (done_in && (active_units != '0)) begin
            cap_d   = relu_in;
            mask_d  = active_units;
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
          end
        end
        DRAIN: begin
          // A full buffer discards the word but still consumes its mask bit.
          if (full_s) begin
            ovf_d = 1'b1;
          end else begin
            we_s    = 1'b1;
            count_d = count_q + (AW+1)'(1);
          end
          if (done_in) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_d;
          end
          mask_d = mask_rem_s;
          if (mask_rem_s == '0) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = IDLE;
          mask_d  = '0;
        end
      endcase
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cap_q   <= '0;
      mask_q  <= '0;
      base_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Buffer storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[waddr_s] <= cap_q[sel_s];
    end
  end

  // Registered read port; same-address write in the same cycle returns old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= mem[rd_addr];
      end
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign result_count = count_q;
  assign busy         = (state_q == DRAIN);
  assign full         = full_s;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_relu_result_writeback.sv
// Self-checking bench for relu_result_writeback: table vectors, directed corner
// sequences and randomized pulses against a behavioural buffer model.
module tb_relu_result_writeback;

  localparam int DEPTH = 64;

  logic             clk = 1'b0;
  logic             reset, clear, done_in, rd_en;
  logic [5:0]       base_addr, rd_addr;
  logic [1:0][15:0] relu_in;
  logic [1:0]       active_units;
  logic [15:0]      rd_data;
  logic             rd_valid, busy, full, overflow;
  logic [6:0]       result_count;

  relu_result_writeback dut (
    .clk(clk), .reset(reset), .clear(clear), .base_addr(base_addr),
    .done_in(done_in), .relu_in(relu_in), .active_units(active_units),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .result_count(result_count), .busy(busy), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: buffer contents, fill level, base and sticky flag.
  logic [15:0] m_mem [DEPTH];
  bit          m_vld [DEPTH];
  int          m_cnt, m_base;
  bit          m_ovf;

  typedef struct {
    logic [1:0]  act;
    logic [15:0] u0;
    logic [15:0] u1;
    int          exp_busy;
    int          exp_cnt;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_pulse(input logic [1:0] act, input logic [15:0] u0, input logic [15:0] u1);
    logic [15:0] v [2];
    v[0] = u0;
    v[1] = u1;
    for (int i = 0; i < 2; i++) begin
      if (act[i]) begin
        if (m_cnt < DEPTH) begin
          m_mem[(m_base + m_cnt) % DEPTH] = v[i];
          m_vld[(m_base + m_cnt) % DEPTH] = 1'b1;
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic do_clear(input int b);
    clear = 1'b1;
    base_addr = 6'(b);
    step();
    clear = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_base = b;
  endtask

  // One pulse; optionally a colliding pulse on the first busy cycle.
  task automatic do_pulse(input logic [1:0] act, input logic [15:0] u0, input logic [15:0] u1,
                          input bit collide, output int bcyc);
    done_in = 1'b1;
    relu_in[0] = u0;
    relu_in[1] = u1;
    active_units = act;
    step();
    done_in = 1'b0;
    bcyc = 0;
    for (int c = 0; c < 8 && busy; c++) begin
      if (c == 0 && collide) begin
        done_in = 1'b1;
        relu_in[0] = 16'hBEEF;
        relu_in[1] = 16'hDEAD;
        active_units = 2'b11;
      end
      bcyc++;
      step();
      done_in = 1'b0;
    end
    model_pulse(act, u0, u1);
    if (collide && act != 2'b00) m_ovf = 1'b1;
    check("result_count", int'(result_count), m_cnt);
    check("full", int'(full), int'(m_cnt == DEPTH));
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic do_read(input int a, input logic [15:0] exp);
    rd_en = 1'b1;
    rd_addr = 6'(a);
    step();
    rd_en = 1'b0;
    check("rd_valid", int'(rd_valid), 1);
    check($sformatf("rd_data[%0d]", a), int'(rd_data), int'(exp));
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      if (m_vld[a]) do_read(a, m_mem[a]);
    end
    step();
    check("rd_valid_idle", int'(rd_valid), 0);
  endtask

  initial begin
    int bc;
    logic [1:0] ra;
    vecs[0] = '{act: 2'b11, u0: 16'h0011, u1: 16'h0022, exp_busy: 2, exp_cnt: 2};
    vecs[1] = '{act: 2'b10, u0: 16'h0099, u1: 16'h0055, exp_busy: 1, exp_cnt: 3};
    vecs[2] = '{act: 2'b00, u0: 16'h0066, u1: 16'h0067, exp_busy: 0, exp_cnt: 3};
    vecs[3] = '{act: 2'b01, u0: 16'h0077, u1: 16'h0088, exp_busy: 1, exp_cnt: 4};
    for (int a = 0; a < DEPTH; a++) m_vld[a] = 1'b0;
    m_cnt = 0; m_base = 0; m_ovf = 1'b0;
    reset = 1'b1; clear = 1'b0; done_in = 1'b0; rd_en = 1'b0;
    base_addr = '0; rd_addr = '0; relu_in = '0; active_units = '0;
    step();
    step();
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_count", int'(result_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    step();

    // Ordered writes, mask skip, empty mask.
    do_clear(0);
    for (int i = 0; i < 4; i++) begin
      do_pulse(vecs[i].act, vecs[i].u0, vecs[i].u1, 1'b0, bc);
      check("vec_busy_cycles", bc, vecs[i].exp_busy);
      check("vec_count", int'(result_count), vecs[i].exp_cnt);
    end
    do_read(1, 16'h0022);
    do_read(2, 16'h0055);

    // Busy collision: second pulse dropped, first intact.
    do_pulse(2'b11, 16'h0A0A, 16'h0B0B, 1'b1, bc);
    check("collide_busy_cycles", bc, 2);
    check("collide_overflow", int'(overflow), 1);
    read_all();

    // Fill from base 62 with wrap, then one pulse past full.
    do_clear(62);
    for (int i = 0; i < 32; i++) begin
      do_pulse(2'b11, 16'(16'h1000 + 2 * i), 16'(16'h1001 + 2 * i), 1'b0, bc);
      check("fill_busy_cycles", bc, 2);
    end
    check("fill_full", int'(full), 1);
    check("fill_no_overflow", int'(overflow), 0);
    do_read(62, 16'h1000);
    do_read(0, 16'h1002);
    do_read(61, 16'h103F);
    do_pulse(2'b11, 16'h2222, 16'h3333, 1'b0, bc);
    check("full_busy_cycles", bc, 2);
    check("full_overflow", int'(overflow), 1);
    read_all();

    // Clear with done_in in the same cycle.
    clear = 1'b1;
    base_addr = 6'd10;
    done_in = 1'b1;
    active_units = 2'b11;
    relu_in[0] = 16'h4444;
    relu_in[1] = 16'h5555;
    step();
    clear = 1'b0;
    done_in = 1'b0;
    m_cnt = 0; m_ovf = 1'b0; m_base = 10;
    check("clr_busy", int'(busy), 0);
    check("clr_count", int'(result_count), 0);
    check("clr_overflow", int'(overflow), 0);
    do_pulse(2'b11, 16'h0C0C, 16'h0D0D, 1'b0, bc);
    do_read(10, 16'h0C0C);
    do_read(11, 16'h0D0D);

    // Reset after the first of two drain writes.
    do_clear(10);
    done_in = 1'b1;
    active_units = 2'b11;
    relu_in[0] = 16'hAAAA;
    relu_in[1] = 16'hBBBB;
    step();
    done_in = 1'b0;
    step();
    m_mem[10] = 16'hAAAA;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_count", int'(result_count), 0);
    check("mid_rst_full", int'(full), 0);
    check("mid_rst_overflow", int'(overflow), 0);
    check("mid_rst_rd_valid", int'(rd_valid), 0);
    check("mid_rst_rd_data", int'(rd_data), 0);
    step();
    reset = 1'b0;
    m_cnt = 0; m_ovf = 1'b0; m_base = 0;
    step();
    check("post_rst_busy", int'(busy), 0);
    do_read(10, 16'hAAAA);
    do_read(11, 16'h0D0D);

    // Randomized pulses, collisions and fill-over against the model.
    do_clear(int'($urandom_range(0, DEPTH - 1)));
    for (int i = 0; i < 45; i++) begin
      ra = 2'($urandom_range(0, 3));
      do_pulse(ra, 16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0), bc);
      check("rand_busy_cycles", bc, $countones(ra));
    end
    read_all();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/relu_result_writeback.md
# relu_result_writeback

Downstream stage of the tensor processing unit. It captures the per-unit ReLU results on each `done` pulse and writes them in order into an on-chip output image buffer. Inactive units are skipped. The host reads the buffer back through a registered read port. The block tracks the fill level, flags results that were lost, and sits between the dot-product/ReLU datapath and host readout.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of one result word
- `IMAGE_WIDTH`, 8, output image width
- `IMAGE_HEIGHT`, 8, output image height
- `NUM_UNITS`, 2, number of parallel dot-product units
- Derived: `DEPTH = IMAGE_WIDTH*IMAGE_HEIGHT`, `AW = $clog2(DEPTH)`

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `clear`, in, 1: synchronous restart of the write stream.
- `base_addr`, in, AW: start address, latched on `clear`.
- `done_in`, in, 1: one-cycle pulse; `relu_in` is valid in that cycle.
- `relu_in`, in, [NUM_UNITS][DATA_WIDTH]: per-unit ReLU results.
- `active_units`, in, NUM_UNITS: units that produced a valid result, sampled with `done_in`.
- `rd_en`, in, 1: host read request.
- `rd_addr`, in, AW: host read address.
- `rd_data`, out, DATA_WIDTH: read data.
- `rd_valid`, out, 1: `rd_data` is valid.
- `result_count`, out, AW+1: number of words written since `clear`, range 0..DEPTH.
- `busy`, out, 1: draining captured results.
- `full`, out, 1: `result_count == DEPTH`.
- `overflow`, out, 1: sticky flag that a result was lost.

## Operation
- FSM states are IDLE and DRAIN. `busy = (state == DRAIN)`.
- **Capture (IDLE).** When `done_in=1` and `active_units != 0`:
  - latch `relu_in` into the capture registers;
  - latch `active_units` into the pending mask;
  - go to DRAIN.
  - With `done_in=1` and `active_units == 0`, stay in IDLE; no write, no flag.
- **Drain.** Each DRAIN cycle:
  - select the lowest set bit i of the pending mask;
  - if not full, write capture[i] to `mem[(latched_base + result_count) mod DEPTH]` and increment `result_count`;
  - clear bit i;
  - when the mask becomes zero, go to IDLE.
- **Full.** Writes are suppressed while `full=1`. Each discarded word sets `overflow`. Draining still consumes the mask, one bit per cycle.
- **done_in while busy.** The pulse is dropped, the capture registers stay unchanged, and `overflow` is set.
- **Address wrap.** The write address wraps modulo DEPTH, so a nonzero `base_addr` wraps past DEPTH-1 to 0. `result_count` itself never wraps; it saturates at DEPTH.
- **clear** (priority over everything except `reset`):
  - state goes to IDLE, `result_count` to 0, `overflow` to 0, the pending mask to 0;
  - `base_addr` is latched;
  - memory contents are retained.
  - `done_in` in the same cycle as `clear` is ignored and does not set `overflow`.
- **Read port.**
  - `rd_en` at cycle T gives `rd_data = mem[rd_addr]` and `rd_valid=1` at T+1. `rd_valid=0` otherwise.
  - A read and a write to the same address in the same cycle return the old data.
- **Memory.** Inferred single-write, single-read RAM; not reset.

## Timing
- **Reset values:** `rd_data=0`, `rd_valid=0`, `result_count=0`, `busy=0`, `full=0`, `overflow=0`, state IDLE, latched base 0.
- **Reset mid-drain:** pending results are discarded immediately. Writes already completed remain in memory.
- **Drain cadence:** with `done_in` at cycle T and k active units, the writes occur on the edges ending cycles T+1..T+k.
  - `busy` is 1 during T+1..T+k.
  - IDLE resumes at T+k+1, where a new `done_in` is accepted.
- **Back-to-back results:** maximum sustained rate is one `done_in` per k+1 cycles.
- **Counter outputs:** `result_count` and `full` update one cycle after each write.
- **Overflow timing:** `overflow` rises the cycle after the dropped or discarded event.

## Test plan
- **Ordered write, both units.** Reset, `clear` with base=0, `done_in` with relu_in={u1=0x0022, u0=0x0011} and active=2'b11.
  - `busy` is high for 2 cycles.
  - mem[0]=0x0011, mem[1]=0x0022; `result_count`=2.
  - Reading addr 1 gives 0x0022 with `rd_valid` one cycle after `rd_en`.
- **Mask skip.** `done_in` with active=2'b10 and u1=0x0055.
  - One write of 0x0055 at the next address; `busy` lasts one cycle.
  - active=2'b00 produces no write and no `busy`.
- **Busy collision.** `done_in` on the cycle after an accepted pulse.
  - The second pulse is dropped; `overflow`=1.
  - The first pulse's two writes are intact.
- **Fill and wrap.**
  - base=62, 32 pulses with active=2'b11: addresses 62, 63, 0, 1, …; `full`=1 at count 64.
  - A 33rd pulse writes nothing; `overflow`=1; `busy` lasts 2 cycles.
- **Clear priority.** Assert `clear` together with `done_in`.
  - No write; count=0; `overflow`=0.
  - The new base is used by the next pulse.
- **Async reset mid-drain.** Assert `reset` in DRAIN after the first write.
  - All outputs go to 0 immediately.
  - mem keeps the first word; the second word is never written.
